// File: rtl/team_12_pkg.sv
// Shared types and constants for the team_12 keypad front end.
package team_12_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    PRESS = 2'd2,
    HELD  = 2'd3
  } scan_state_t;

  typedef logic [3:0] key_code_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Lowest-index column pulled low; only meaningful when some column is low.
  function automatic logic [1:0] first_low(input logic [NUM_COLS-1:0] cols);
    first_low = 2'd3;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!cols[i]) first_low = 2'(i);
    end
  endfunction

endpackage

// File: rtl/team_12_key_fifo.sv
// Two-entry key code buffer; entry0 is always the head so the output is a flop.
module team_12_key_fifo
  import team_12_pkg::*;
(
  input  logic      clk,
  input  logic      nrst,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  key_code_t din,
  output key_code_t head,
  output logic      full,
  output logic      empty
);

  key_code_t   entry0_q, entry0_d;
  key_code_t   entry1_q, entry1_d;
  logic [1:0]  count_q, count_d;
  logic        pop_ok;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    pop_ok   = pop && (count_q != 2'd0);
    if (flush) begin
      entry0_d = '0;
      entry1_d = '0;
      count_d  = 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) begin
            entry0_d = din;
            count_d  = 2'd1;
          end else if (count_q == 2'd1) begin
            entry1_d = din;
            count_d  = 2'd2;
          end
        end
        2'b01: begin
          entry0_d = entry1_q;
          count_d  = count_q - 2'd1;
        end
        // Simultaneous push and pop keeps the occupancy, even when full.
        2'b11: begin
          if (count_q == 2'd1) begin
            entry0_d = din;
          end else begin
            entry0_d = entry1_q;
            entry1_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign head  = entry0_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/team_12_keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sync, press/release debounce,
// and a small buffer feeding key codes to the core over valid/ready.
module team_12_keypad_scanner
  import team_12_pkg::*;
#(
  parameter int SETTLE_CYC   = 16,
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic [NUM_COLS-1:0] cols_in,
  output logic [NUM_ROWS-1:0] rows_out,
  output key_code_t           key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                overflow
);

  localparam int CNT_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);

  logic [NUM_COLS-1:0] sync1_q, cols_s_q;
  scan_state_t         state_q, state_d;
  logic [1:0]          row_q, row_d;
  logic [1:0]          col_q, col_d;
  logic [CNT_W-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0]    deb_q, deb_d;
  logic [NUM_ROWS-1:0] rows_out_q, rows_out_d;
  logic                overflow_q, overflow_d;
  logic                push, pop, col_low;
  logic                fifo_full, fifo_empty;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    settle_d = settle_q;
    deb_d    = deb_q;
    push     = 1'b0;
    col_low  = ~cols_s_q[col_q];
    if (!en) begin
      state_d  = IDLE;
      row_d    = 2'd0;
      col_d    = 2'd0;
      settle_d = '0;
      deb_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SCAN;
          row_d    = 2'd0;
          settle_d = '0;
        end
        SCAN: begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            if (cols_s_q != 4'hF) begin
              col_d   = first_low(cols_s_q);
              deb_d   = '0;
              state_d = PRESS;
            end else begin
              row_d = row_q + 2'd1;
            end
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        PRESS: begin
          if (col_low) begin
            if (deb_q == DEB_LAST) begin
              push    = 1'b1;
              deb_d   = '0;
              state_d = HELD;
            end else begin
              deb_d = deb_q + 1'b1;
            end
          end else begin
            row_d    = row_q + 2'd1;
            settle_d = '0;
            deb_d    = '0;
            state_d  = SCAN;
          end
        end
        HELD: begin
          // Release needs an unbroken run of high samples; other keys are ignored.
          if (col_low) begin
            deb_d = '0;
          end else if (deb_q == DEB_LAST) begin
            row_d    = row_q + 2'd1;
            settle_d = '0;
            deb_d    = '0;
            state_d  = SCAN;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    rows_out_d = (state_d == IDLE) ? 4'hF : ~(4'b0001 << row_d);
    overflow_d = overflow_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q    <= 4'hF;
      cols_s_q   <= 4'hF;
      state_q    <= SCAN;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      settle_q   <= '0;
      deb_q      <= '0;
      rows_out_q <= 4'hF;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= cols_in;
      cols_s_q   <= sync1_q;
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      settle_q   <= settle_d;
      deb_q      <= deb_d;
      rows_out_q <= rows_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign pop = key_valid & key_ready;

  team_12_key_fifo u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .flush (~en),
    .push  (push),
    .pop   (pop),
    .din   ({row_q, col_q}),
    .head  (key_code),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign key_valid = ~fifo_empty;
  assign rows_out  = rows_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_team_12_keypad_scanner.sv
// Bench for the keypad scanner: a keypad model, table-driven presses, timed corner
// cases and random presses checked against an expected-code queue.
module tb_team_12_keypad_scanner;

  logic       clk;
  logic       nrst;
  logic       en;
  logic [3:0] cols_in;
  logic [3:0] rows_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Keypad model: one key, shorting its column low while its row is driven low.
  logic       kp_down;
  logic [1:0] kp_row, kp_col;

  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    int         hold;
    int         gap;
    logic [3:0] exp_code;
  } vec_t;

  vec_t vecs[5];

  team_12_keypad_scanner #(
    .SETTLE_CYC   (4),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .cols_in   (cols_in),
    .rows_out  (rows_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cols_in = 4'hF;
    if (kp_down && (rows_out[kp_row] == 1'b0)) cols_in[kp_col] = 1'b0;
  end

  // Every handshake the consumer sees.
  always @(negedge clk) begin
    if (nrst && key_valid && key_ready) got_q.push_back(key_code);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] row, input logic [1:0] col, input logic down);
    kp_row  = row;
    kp_col  = col;
    kp_down = down;
  endtask

  task automatic runCycles(input int n, input bit rand_ready);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) key_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pressRelease(input logic [1:0] row, input logic [1:0] col, input int hold, input int gap);
    applyStimulus(row, col, 1'b1);
    runCycles(hold, 1'b0);
    applyStimulus(row, col, 1'b0);
    runCycles(gap, 1'b0);
  endtask

  // Returns at the negedge right after row 0 starts being driven following row 3.
  task automatic waitRow0Start(input string name);
    logic [3:0] prev;
    bit         found;
    found = 1'b0;
    @(negedge clk);
    prev = rows_out;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (rows_out == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = rows_out;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: row 0 start not seen, rows_out=%b", name, rows_out);
    end
  endtask

  initial begin
    int r, c, hold, gap;
    bit seen;

    vecs[0] = '{row: 2'd2, col: 2'd1, hold: 50,  gap: 30, exp_code: 4'b1001};
    vecs[1] = '{row: 2'd0, col: 2'd0, hold: 50,  gap: 30, exp_code: 4'b0000};
    vecs[2] = '{row: 2'd1, col: 2'd2, hold: 60,  gap: 30, exp_code: 4'b0110};
    vecs[3] = '{row: 2'd3, col: 2'd0, hold: 45,  gap: 30, exp_code: 4'b1100};
    vecs[4] = '{row: 2'd3, col: 2'd3, hold: 200, gap: 30, exp_code: 4'b1111};

    nrst      = 1'b0;
    en        = 1'b1;
    key_ready = 1'b1;
    applyStimulus(2'd0, 2'd0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_rows_out", 32'(rows_out), 32'hF);
    checkOutput("reset_key_valid", 32'(key_valid), 32'h0);
    checkOutput("reset_key_code", 32'(key_code), 32'h0);
    checkOutput("reset_overflow", 32'(overflow), 32'h0);
    @(posedge clk);
    #1 nrst = 1'b1;
    runCycles(5, 1'b0);

    $display("[TB] table-driven presses");
    for (int i = 0; i < 5; i++) begin
      got_q.delete();
      pressRelease(vecs[i].row, vecs[i].col, vecs[i].hold, vecs[i].gap);
      checkOutput($sformatf("vec%0d_count", i), 32'(got_q.size()), 32'd1);
      checkOutput($sformatf("vec%0d_code", i),
                  (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'(vecs[i].exp_code));
    end

    // Idle scan cadence after the held key was released
    waitRow0Start("cadence_sync");
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput($sformatf("cadence_%0d", i), 32'(rows_out), 32'(4'hF ^ (4'b0001 << (i / 4))));
    end
    runCycles(2, 1'b0);

    $display("[TB] bounce on row 0 / col 0");
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(2'd0, 2'd0, (i % 2) == 0);
      runCycles(3, 1'b0);
    end
    checkOutput("bounce_no_key", 32'(got_q.size()), 32'd0);
    pressRelease(2'd0, 2'd0, 50, 30);
    checkOutput("bounce_count", 32'(got_q.size()), 32'd1);
    checkOutput("bounce_code", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'h0);

    $display("[TB] backpressure");
    got_q.delete();
    key_ready = 1'b0;
    pressRelease(2'd0, 2'd1, 40, 30);
    pressRelease(2'd0, 2'd2, 40, 30);
    checkOutput("bp_valid", 32'(key_valid), 32'h1);
    checkOutput("bp_head", 32'(key_code), 32'h1);
    checkOutput("bp_no_overflow_yet", 32'(overflow), 32'h0);
    pressRelease(2'd0, 2'd3, 40, 30);
    checkOutput("bp_overflow", 32'(overflow), 32'h1);
    checkOutput("bp_head_kept", 32'(key_code), 32'h1);
    key_ready = 1'b1;
    runCycles(10, 1'b0);
    checkOutput("bp_pop_count", 32'(got_q.size()), 32'd2);
    checkOutput("bp_pop0", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'h1);
    checkOutput("bp_pop1", (got_q.size() > 1) ? 32'(got_q[1]) : 32'hFFFF_FFFF, 32'h2);
    checkOutput("bp_drained", 32'(key_valid), 32'h0);

    $display("[TB] press latency");
    key_ready = 1'b0;
    waitRow0Start("latency_sync");
    applyStimulus(2'd0, 2'd0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 11) checkOutput("latency_not_yet", 32'(key_valid), 32'h0);
      if (k == 12) checkOutput("latency_valid", 32'(key_valid), 32'h1);
    end
    checkOutput("latency_code", 32'(key_code), 32'h0);
    applyStimulus(2'd0, 2'd0, 1'b0);
    runCycles(20, 1'b0);

    $display("[TB] enable drop during debounce");
    waitRow0Start("endrop_sync");
    applyStimulus(2'd0, 2'd0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) en = 1'b0;
    end
    checkOutput("endrop_rows_idle", 32'(rows_out), 32'hF);
    checkOutput("endrop_flushed", 32'(key_valid), 32'h0);
    repeat (10) @(negedge clk);
    checkOutput("endrop_no_push", 32'(key_valid), 32'h0);
    checkOutput("endrop_overflow_kept", 32'(overflow), 32'h1);
    applyStimulus(2'd0, 2'd0, 1'b0);
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("enable_row0", 32'(rows_out), 32'hE);
      if (k == 4) checkOutput("enable_row0_hold", 32'(rows_out), 32'hE);
      if (k == 5) checkOutput("enable_row1", 32'(rows_out), 32'hD);
    end
    runCycles(30, 1'b0);
    checkOutput("enable_idle_no_key", 32'(key_valid), 32'h0);

    $display("[TB] async reset while held");
    applyStimulus(2'd1, 2'd1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      runCycles(1, 1'b0);
      if (key_valid) seen = 1'b1;
    end
    checkOutput("held_key_seen", 32'(seen), 32'h1);
    runCycles(10, 1'b0);
    checkOutput("held_code", 32'(key_code), 32'h5);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    checkOutput("areset_rows_out", 32'(rows_out), 32'hF);
    checkOutput("areset_key_valid", 32'(key_valid), 32'h0);
    checkOutput("areset_key_code", 32'(key_code), 32'h0);
    checkOutput("areset_overflow", 32'(overflow), 32'h0);
    applyStimulus(2'd1, 2'd1, 1'b0);
    runCycles(3, 1'b0);
    nrst = 1'b1;
    runCycles(5, 1'b0);

    $display("[TB] random presses");
    got_q.delete();
    exp_q.delete();
    for (int n = 0; n < 10; n++) begin
      r    = $urandom_range(0, 3);
      c    = $urandom_range(0, 3);
      hold = $urandom_range(45, 70);
      gap  = $urandom_range(30, 40);
      exp_q.push_back(4'(r * 4 + c));
      applyStimulus(2'(r), 2'(c), 1'b1);
      runCycles(hold, 1'b1);
      applyStimulus(2'(r), 2'(c), 1'b0);
      runCycles(gap, 1'b1);
    end
    key_ready = 1'b1;
    runCycles(10, 1'b0);
    checkOutput("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      checkOutput($sformatf("rand_code%0d", i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    checkOutput("rand_overflow", 32'(overflow), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
